// File: rtl/snake_pkg.sv
// Shared snake game types: grid geometry, body FSM encoding and the cell coordinate.
package snake_pkg;

   localparam int W      = 6;
   localparam int GRID_W = 40;
   localparam int GRID_H = 30;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      COMMIT = 3'd2,
      QSCAN  = 3'd3,
      DEAD   = 3'd4
   } state_t;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
   } coord_t;

endpackage

// File: rtl/snake_seg_cmp.sv
// Single-segment comparator: equality of two cells plus a grid-bounds check on the first.
module snake_seg_cmp #(
   parameter int GRID_W = snake_pkg::GRID_W,
   parameter int GRID_H = snake_pkg::GRID_H
) (
   input  snake_pkg::coord_t a,
   input  snake_pkg::coord_t b,
   input  logic              en,
   output logic              match,
   output logic              out_of_grid
);

   import snake_pkg::*;

   // Both flags are forced low when the compare slot is idle.
   always_comb begin
      match       = en && (a == b);
      out_of_grid = en && ((int'(a.x) >= GRID_W) || (int'(a.y) >= GRID_H));
   end

endmodule

// File: rtl/snake_body.sv
// Snake body store: circular buffer of segments with serial collision check and
// serial occupancy lookup, one segment compared per cycle.
module snake_body #(
   parameter int W        = snake_pkg::W,
   parameter int MAX_LEN  = 32,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 20,
   parameter int START_Y  = 15,
   parameter int GRID_W   = snake_pkg::GRID_W,
   parameter int GRID_H   = snake_pkg::GRID_H
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       i_Step,
   input  logic [W-1:0]               i_Next_x,
   input  logic [W-1:0]               i_Next_y,
   input  logic                       i_Grow,
   input  logic                       i_Qry,
   input  logic [W-1:0]               i_Qry_x,
   input  logic [W-1:0]               i_Qry_y,
   output logic [W-1:0]               o_Head_x,
   output logic [W-1:0]               o_Head_y,
   output logic [$clog2(MAX_LEN):0]   o_Length,
   output logic                       o_Busy,
   output logic                       o_Done,
   output logic                       o_Qry_done,
   output logic                       o_Qry_hit,
   output logic                       o_Collide
);

   import snake_pkg::*;

   localparam int PW = $clog2(MAX_LEN);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

   state_t        state, state_n;
   coord_t        body [MAX_LEN];
   logic [PW-1:0] hp;
   logic [PW-1:0] idx;
   coord_t        tgt_q;      // proposed head during CHECK, query cell during QSCAN
   logic          grow_q;
   coord_t        seg;
   logic [LW-1:0] chk_len;
   logic [LW-1:0] idx_ext;
   logic          chk_last, qry_last;
   logic          hit, wall;

   // Segment k after reset sits at slot (0-k) mod MAX_LEN, trailing left of the head.
   function automatic coord_t init_seg(int i);
      int     k;
      coord_t c;
      k = (MAX_LEN - i) % MAX_LEN;
      c = '0;
      if (k < INIT_LEN) begin
         c.x = W'(START_X - k);
         c.y = W'(START_Y);
      end
      return c;
   endfunction

   assign o_Head_x = body[hp].x;
   assign o_Head_y = body[hp].y;

   // Scan bookkeeping: the tail slot is excluded when it is about to be vacated
   // (no growth, or growth ignored because the buffer is full).
   always_comb begin
      seg      = body[hp - idx];
      idx_ext  = {1'b0, idx};
      chk_len  = (grow_q && (o_Length < MAX_L)) ? o_Length : o_Length - 1'b1;
      chk_last = (idx_ext == chk_len - 1'b1);
      qry_last = (idx_ext == o_Length - 1'b1);
   end

   snake_seg_cmp #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_cmp (
      .a           (tgt_q),
      .b           (seg),
      .en          ((state == CHECK) || (state == QSCAN)),
      .match       (hit),
      .out_of_grid (wall)
   );

   // Next-state logic; a step request outranks a simultaneous query.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (i_Step)     state_n = CHECK;
            else if (i_Qry) state_n = QSCAN;
         end
         CHECK: begin
            if (hit || wall)   state_n = DEAD;
            else if (chk_last) state_n = COMMIT;
         end
         COMMIT: state_n = IDLE;
         QSCAN: begin
            if (hit || qry_last) state_n = IDLE;
         end
         DEAD:    state_n = DEAD;
         default: state_n = IDLE;
      endcase
   end

   // Control registers: state, registered status flags, request latches and scan index.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         o_Busy     <= 1'b0;
         o_Done     <= 1'b0;
         o_Qry_done <= 1'b0;
         o_Qry_hit  <= 1'b0;
         o_Collide  <= 1'b0;
         idx        <= '0;
         tgt_q      <= '0;
         grow_q     <= 1'b0;
      end else begin
         state      <= state_n;
         o_Busy     <= (state_n != IDLE);
         o_Collide  <= (state_n == DEAD);
         o_Done     <= (state == COMMIT);
         o_Qry_done <= (state == QSCAN) && (state_n == IDLE);
         if ((state == QSCAN) && (state_n == IDLE))
            o_Qry_hit <= hit;
         case (state)
            IDLE: begin
               if (i_Step) begin
                  tgt_q.x <= i_Next_x;
                  tgt_q.y <= i_Next_y;
                  grow_q  <= i_Grow;
                  idx     <= '0;
               end else if (i_Qry) begin
                  tgt_q.x <= i_Qry_x;
                  tgt_q.y <= i_Qry_y;
                  idx     <= '0;
               end
            end
            CHECK, QSCAN: idx <= idx + 1'b1;
            default: ;
         endcase
      end
   end

   // Body storage: push the new head on commit; the tail drops off implicitly
   // because only o_Length segments behind hp are ever scanned.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         hp       <= '0;
         o_Length <= LW'(INIT_LEN);
         for (int i = 0; i < MAX_LEN; i++)
            body[i] <= init_seg(i);
      end else if (state == COMMIT) begin
         hp               <= hp + 1'b1;
         body[hp + 1'b1]  <= tgt_q;
         if (grow_q && (o_Length < MAX_L))
            o_Length <= o_Length + 1'b1;
      end
   end

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench: dut0 uses default sizing, dut1 a 4-deep buffer for pointer wrap.
module tb_snake_body;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst;
   logic       stp [2], grw [2], qry [2];
   logic [5:0] nx [2], ny [2], qx [2], qy [2];
   logic [5:0] hx [2], hy [2];
   logic [5:0] len0;
   logic [2:0] len1;
   logic [5:0] lenx [2];
   logic       busy [2], done [2], qdone [2], qhit [2], coll [2];

   assign lenx[0] = len0;
   assign lenx[1] = {3'b000, len1};

   snake_body u0 (
      .Clk(clk), .Rst(rst), .i_Step(stp[0]), .i_Next_x(nx[0]), .i_Next_y(ny[0]),
      .i_Grow(grw[0]), .i_Qry(qry[0]), .i_Qry_x(qx[0]), .i_Qry_y(qy[0]),
      .o_Head_x(hx[0]), .o_Head_y(hy[0]), .o_Length(len0), .o_Busy(busy[0]),
      .o_Done(done[0]), .o_Qry_done(qdone[0]), .o_Qry_hit(qhit[0]), .o_Collide(coll[0])
   );

   snake_body #(.MAX_LEN(4)) u1 (
      .Clk(clk), .Rst(rst), .i_Step(stp[1]), .i_Next_x(nx[1]), .i_Next_y(ny[1]),
      .i_Grow(grw[1]), .i_Qry(qry[1]), .i_Qry_x(qx[1]), .i_Qry_y(qy[1]),
      .o_Head_x(hx[1]), .o_Head_y(hy[1]), .o_Length(len1), .o_Busy(busy[1]),
      .o_Done(done[1]), .o_Qry_done(qdone[1]), .o_Qry_hit(qhit[1]), .o_Collide(coll[1])
   );

   typedef struct {
      int d;
      bit is_q;
      int hx, hy, len;
      bit hit;
      int issue, lat;
   } exp_t;

   exp_t sb [$];
   exp_t me;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done/query-done pulse must match the oldest expected record.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (done[d] || qdone[d]) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output dut%0d done=%0b qdone=%0b cycle %0d",
                        d, done[d], qdone[d], cyc);
            end else begin
               me = sb.pop_front();
               chk("dut_id", d, me.d);
               chk("out_kind", int'(qdone[d]), int'(me.is_q));
               chk("latency", cyc - me.issue, me.lat);
               if (me.is_q) begin
                  chk("qry_hit", int'(qhit[d]), int'(me.hit));
               end else begin
                  chk("head_x", int'(hx[d]), me.hx);
                  chk("head_y", int'(hy[d]), me.hy);
                  chk("length", int'(lenx[d]), me.len);
               end
            end
         end
      end
   end

   task automatic push(int d, bit is_q, int ehx, int ehy, int elen, bit ehit, int lat);
      exp_t e;
      e.d = d; e.is_q = is_q; e.hx = ehx; e.hy = ehy; e.len = elen;
      e.hit = ehit; e.issue = cyc; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic wait_idle(int d);
      int n;
      n = 0;
      while ((busy[d] || sb.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait_timeout", int'(n >= 100), 0);
   endtask

   task automatic do_step(int d, int x, int y, bit g, bit also_q,
                          int ehx, int ehy, int elen, int lat);
      push(d, 1'b0, ehx, ehy, elen, 1'b0, lat);
      nx[d] = 6'(x); ny[d] = 6'(y); grw[d] = g; stp[d] = 1'b1;
      if (also_q) begin
         qx[d] = 6'(x); qy[d] = 6'(y); qry[d] = 1'b1;
      end
      @(negedge clk);
      stp[d] = 1'b0; grw[d] = 1'b0; qry[d] = 1'b0;
      wait_idle(d);
   endtask

   task automatic do_qry(int d, int x, int y, bit ehit, int lat);
      push(d, 1'b1, 0, 0, 0, ehit, lat);
      qx[d] = 6'(x); qy[d] = 6'(y); qry[d] = 1'b1;
      @(negedge clk);
      qry[d] = 1'b0;
      wait_idle(d);
   endtask

   // Step that must end in DEAD exactly dl cycles after issue.
   task automatic step_die(int d, int x, int y, bit g, int dl);
      nx[d] = 6'(x); ny[d] = 6'(y); grw[d] = g; stp[d] = 1'b1;
      @(negedge clk);
      stp[d] = 1'b0; grw[d] = 1'b0;
      repeat (dl - 2) @(negedge clk);
      chk("collide_early", int'(coll[d]), 0);
      @(negedge clk);
      chk("collide", int'(coll[d]), 1);
      chk("busy_dead", int'(busy[d]), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset(int d);
      chk("rst_head_x", int'(hx[d]), 20);
      chk("rst_head_y", int'(hy[d]), 15);
      chk("rst_length", int'(lenx[d]), 3);
      chk("rst_busy", int'(busy[d]), 0);
      chk("rst_done", int'(done[d]), 0);
      chk("rst_qdone", int'(qdone[d]), 0);
      chk("rst_qhit", int'(qhit[d]), 0);
      chk("rst_collide", int'(coll[d]), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         stp[d] = 1'b0; grw[d] = 1'b0; qry[d] = 1'b0;
         nx[d] = '0; ny[d] = '0; qx[d] = '0; qy[d] = '0;
      end
      do_reset();
      chk_reset(0);
      chk_reset(1);

      // basic move, then occupancy lookups
      do_step(0, 21, 15, 1'b0, 1'b0, 21, 15, 3, 4);
      do_qry(0, 18, 15, 1'b0, 4);
      do_qry(0, 19, 15, 1'b1, 4);
      repeat (3) @(negedge clk);
      chk("qhit_hold", int'(qhit[0]), 1);
      do_qry(0, 21, 15, 1'b1, 2);

      // growth
      do_step(0, 22, 15, 1'b1, 1'b0, 22, 15, 4, 5);
      do_qry(0, 19, 15, 1'b1, 5);

      // step and query together: query dropped
      do_step(0, 23, 15, 1'b0, 1'b1, 23, 15, 4, 5);

      // second step while busy is ignored
      push(0, 1'b0, 24, 15, 4, 1'b0, 5);
      nx[0] = 6'd24; ny[0] = 6'd15; stp[0] = 1'b1;
      @(negedge clk);
      stp[0] = 1'b0;
      @(negedge clk);
      chk("busy_in_check", int'(busy[0]), 1);
      nx[0] = 6'd30; ny[0] = 6'd3; stp[0] = 1'b1;
      @(negedge clk);
      stp[0] = 1'b0;
      wait_idle(0);
      repeat (6) @(negedge clk);
      chk("single_done_head", int'(hx[0]), 24);

      // wall on x, then everything ignored until reset
      step_die(0, 40, 15, 1'b0, 2);
      nx[0] = 6'd25; ny[0] = 6'd15; stp[0] = 1'b1;
      qx[0] = 6'd24; qy[0] = 6'd15; qry[0] = 1'b1;
      @(negedge clk);
      stp[0] = 1'b0; qry[0] = 1'b0;
      repeat (8) @(negedge clk);
      chk("dead_sticky", int'(coll[0]), 1);
      chk("dead_frozen_x", int'(hx[0]), 24);
      chk("dead_frozen_len", int'(lenx[0]), 4);
      do_reset();
      chk_reset(0);

      // tail chase into a 2x2 loop, then bite segment 2
      do_step(0, 20, 14, 1'b1, 1'b0, 20, 14, 4, 5);
      do_step(0, 19, 14, 1'b0, 1'b0, 19, 14, 4, 5);
      do_step(0, 19, 15, 1'b0, 1'b0, 19, 15, 4, 5);
      do_qry(0, 20, 15, 1'b1, 5);
      step_die(0, 20, 14, 1'b0, 4);

      // pointer wrap on the 4-deep instance
      do_reset();
      chk_reset(1);
      for (int i = 1; i <= 10; i++)
         do_step(1, 20 + i, 15, 1'b0, 1'b0, 20 + i, 15, 3, 4);
      do_qry(1, 28, 15, 1'b1, 4);
      do_qry(1, 27, 15, 1'b0, 4);
      do_step(1, 30, 14, 1'b0, 1'b0, 30, 14, 3, 4);
      do_step(1, 29, 14, 1'b0, 1'b0, 29, 14, 3, 4);
      do_step(1, 28, 14, 1'b0, 1'b0, 28, 14, 3, 4);
      do_qry(1, 30, 15, 1'b0, 4);
      do_qry(1, 29, 14, 1'b1, 3);
      for (int i = 1; i <= 6; i++)
         do_step(1, 28 - i, 14, 1'b1, 1'b0, 28 - i, 14, 4, 5);
      do_qry(1, 25, 14, 1'b1, 5);
      do_qry(1, 26, 14, 1'b0, 5);
      // full buffer: grow ignored, so the tail cell is free to enter
      do_step(1, 25, 14, 1'b1, 1'b0, 25, 14, 4, 5);
      // wall on y
      step_die(1, 25, 30, 1'b0, 2);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
